regfile_scoreboard: RTL

Parametrised, clocked MIPS general-purpose register file. It has NUM_RD combinational read ports, one synchronous write-back port, optional write-to-read bypass and a hardwired zero register. It also holds a per-register busy scoreboard: a register is marked busy when an instruction targeting it issues, and cleared when its write-back lands. The block sits between the decode/issue stage and the write-back stage, and feeds operands plus hazard flags to the stall logic.

---
 rtl/mips_rf_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 56 +++++
 rtl/regfile_scoreboard.sv | 81 ++++++++
 3 files changed

// File: rtl/mips_rf_pkg.sv
// Shared constants for the MIPS register file slice: default widths and
// architectural register aliases used by the datapath and its benches.
package mips_rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    // One-hot decode of a register index into a DEPTH-wide mask.
    function automatic logic [(2**ADDR_W_DEF)-1:0] idx_onehot(input logic [ADDR_W_DEF-1:0] idx);
        logic [(2**ADDR_W_DEF)-1:0] mask_v;
        mask_v = {(2**ADDR_W_DEF){1'b0}};
        mask_v[idx] = 1'b1;
        return mask_v;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, write-back clears, set wins on a
// same-index collision; also looks up the busy bit for every read port.
module rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [DEPTH-1:0]         busy_vec
);

    localparam logic [DEPTH-1:0] ONE_HOT0  = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] KEEP_MASK = (ZERO_REG != 0) ? ~ONE_HOT0 : {DEPTH{1'b1}};

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] set_mask_s;
    logic [DEPTH-1:0] clr_mask_s;
    logic [DEPTH-1:0] busy_nxt_s;

    // Next-state: clear first, then OR the set mask so a new producer supersedes the retiring one.
    always_comb begin
        set_mask_s = issue_valid ? (ONE_HOT0 << issue_addr) : {DEPTH{1'b0}};
        clr_mask_s = wb_en ? (ONE_HOT0 << wb_addr) : {DEPTH{1'b0}};
        busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & KEEP_MASK;
    end

    // Busy flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Hazard flag per read port comes straight from registered state, never bypassed.
    always_comb begin
        rd_busy = {NUM_RD{1'b0}};
        for (int p = 0; p < NUM_RD; p++) begin
            rd_busy[p] = busy_r[rd_addr[p*ADDR_W +: ADDR_W]];
        end
    end

    assign busy_vec = busy_r;

endmodule

// File: rtl/regfile_scoreboard.sv
// MIPS general-purpose register file with NUM_RD combinational read ports,
// one write-back port, optional forwarding, hardwired r0 and a busy scoreboard.
module regfile_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic [DEPTH-1:0]         busy_vec
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              wr_en_s;

    // Writes to the hardwired zero register are dropped before they reach storage.
    always_comb begin
        if ((ZERO_REG != 0) && (wb_addr == ZERO_IDX)) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = wb_en;
        end
    end

    // Storage array, cleared in full by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wb_addr] <= wb_data;
        end
    end

    // Read muxes per port: zero register beats forwarding, forwarding beats storage.
    always_comb begin
        rd_data = {(NUM_RD*DATA_W){1'b0}};
        for (int p = 0; p < NUM_RD; p++) begin
            if ((ZERO_REG != 0) && (rd_addr[p*ADDR_W +: ADDR_W] == ZERO_IDX)) begin
                rd_data[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if ((BYPASS != 0) && wb_en && (wb_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
                rd_data[p*DATA_W +: DATA_W] = wb_data;
            end else begin
                rd_data[p*DATA_W +: DATA_W] = mem_r[rd_addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy),
        .busy_vec    (busy_vec)
    );

endmodule
